fetch_ctrl: RTL and testbench

//   Sequencing controller for the IF stage (pc register, pc mux, pc+4 adder, imem, IF/ID reg).

---
 rtl/fetch_ctrl_pkg.sv | 38 +++
 rtl/fetch_ctrl_if.sv | 40 ++++
 rtl/fetch_wait_timer.sv | 35 +++
 rtl/fetch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the IF-stage fetch controller: state encodings, the NOP
// encoding used by the pipeline-register flush logic, and the control bundle type.
package fetch_ctrl_pkg;

   localparam logic [1:0] S_RESET = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_ERR   = 2'd3;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic imem_req;
      logic pc_we;
      logic pc_sel;
      logic if_id_we;
      logic if_id_flush;
      logic id_ex_flush;
   } fetch_ctl_t;

   // Idle pipeline: nothing advances and IF/ID takes a bubble.
   function automatic fetch_ctl_t ctl_bubble();
      fetch_ctl_t c;
      c             = '0;
      c.if_id_flush = 1'b1;
      return c;
   endfunction

   function automatic fetch_ctl_t ctl_advance();
      fetch_ctl_t c;
      c          = '0;
      c.imem_req = 1'b1;
      c.pc_we    = 1'b1;
      c.if_id_we = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the fetch controller and the IF-stage datapath.
// Perf counter outputs exist only when FETCH_CTRL_PERF_EN is defined.
interface fetch_ctrl_if;

   logic        imem_busy;
   logic        stall_id;
   logic        branch_taken_ex;
   logic [31:0] branch_target_ex;
   logic        imem_req;
   logic        pc_we;
   logic        pc_sel;
   logic [31:0] redirect_pc;
   logic        if_id_we;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        fetch_err;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_bubbles;
`endif

   modport master (
      input  imem_busy, stall_id, branch_taken_ex, branch_target_ex,
`ifdef FETCH_CTRL_PERF_EN
      output perf_fetched, perf_bubbles,
`endif
      output imem_req, pc_we, pc_sel, redirect_pc,
      output if_id_we, if_id_flush, id_ex_flush, fetch_err
   );

   modport slave (
      output imem_busy, stall_id, branch_taken_ex, branch_target_ex,
`ifdef FETCH_CTRL_PERF_EN
      input  perf_fetched, perf_bubbles,
`endif
      input  imem_req, pc_we, pc_sel, redirect_pc,
      input  if_id_we, if_id_flush, id_ex_flush, fetch_err
   );

endinterface

// File: rtl/fetch_wait_timer.sv
// Saturating up-counter with synchronous clear and enable; tc_o is high while the
// count sits at TC. Used for both the post-reset hold and the imem wait timeout.
module fetch_wait_timer #(
   parameter int unsigned TC = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int unsigned    W    = (TC < 2) ? 1 : $clog2(TC + 1);
   localparam logic [W-1:0]   TC_V = W'(TC);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && (cnt_q != TC_V))
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == TC_V);

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencing controller: reset hold-off, multi-cycle imem waits, EX redirects
// (bypassed or deferred until imem completes) and a sticky imem timeout flag.
// Optional perf counters are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned RESET_HOLD_CYCLES = 2,
   parameter int unsigned MAX_WAIT          = 15
) (
   input  logic          clk,
   input  logic          rst,
   fetch_ctrl_if.master  bus
);

   logic [1:0]  state_q, state_d;
   logic        pend_q, pend_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        err_q;

   fetch_ctl_t  ctl;
   logic [31:0] rpc;
   logic        hold_tc, wait_tc;
   logic        wait_clr;

   fetch_wait_timer #(.TC(RESET_HOLD_CYCLES - 1)) u_hold (
      .clk   (clk),
      .rst   (rst),
      .clr_i (1'b0),
      .en_i  (state_q == S_RESET),
      .tc_o  (hold_tc)
   );

   assign wait_clr = (state_d == S_WAIT) && (state_q != S_WAIT);

   fetch_wait_timer #(.TC(MAX_WAIT - 1)) u_wait (
      .clk   (clk),
      .rst   (rst),
      .clr_i (wait_clr),
      .en_i  (state_q == S_WAIT),
      .tc_o  (wait_tc)
   );

   always_comb begin
      ctl       = ctl_bubble();
      rpc       = pend_q ? pend_pc_q : 32'h0;
      state_d   = state_q;
      pend_d    = pend_q;
      pend_pc_d = pend_pc_q;

      case (state_q)
         S_RESET: begin
            if (hold_tc)
               state_d = S_FETCH;
         end

         S_FETCH: begin
            ctl.imem_req = 1'b1;
            if (bus.branch_taken_ex && !bus.imem_busy) begin
               ctl.pc_sel      = 1'b1;
               ctl.pc_we       = 1'b1;
               ctl.id_ex_flush = 1'b1;
               rpc             = bus.branch_target_ex;
            end else if (bus.imem_busy) begin
               state_d = S_WAIT;
               if (bus.branch_taken_ex) begin
                  pend_d          = 1'b1;
                  pend_pc_d       = bus.branch_target_ex;
                  ctl.id_ex_flush = 1'b1;
               end
            end else if (bus.stall_id) begin
               ctl.if_id_flush = 1'b0;
            end else begin
               ctl = ctl_advance();
            end
         end

         S_WAIT: begin
            ctl.imem_req = 1'b1;
            if (bus.imem_busy) begin
               // Only the first redirect is kept; the older branch owns the pc.
               if (bus.branch_taken_ex && !pend_q) begin
                  pend_d          = 1'b1;
                  pend_pc_d       = bus.branch_target_ex;
                  ctl.id_ex_flush = 1'b1;
               end
               if (wait_tc)
                  state_d = S_ERR;
            end else begin
               state_d = S_FETCH;
               if (pend_q) begin
                  ctl.pc_sel = 1'b1;
                  ctl.pc_we  = 1'b1;
                  rpc        = pend_pc_q;
                  pend_d     = 1'b0;
               end else if (bus.branch_taken_ex) begin
                  ctl.pc_sel      = 1'b1;
                  ctl.pc_we       = 1'b1;
                  ctl.id_ex_flush = 1'b1;
                  rpc             = bus.branch_target_ex;
               end else if (bus.stall_id) begin
                  ctl.if_id_flush = 1'b0;
               end else begin
                  ctl = ctl_advance();
               end
            end
         end

         default: begin
            state_d = S_ERR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_RESET;
         pend_q    <= 1'b0;
         pend_pc_q <= 32'h0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
         err_q     <= err_q | (state_d == S_ERR);
      end
   end

   assign bus.imem_req    = ctl.imem_req;
   assign bus.pc_we       = ctl.pc_we;
   assign bus.pc_sel      = ctl.pc_sel;
   assign bus.redirect_pc = rpc;
   assign bus.if_id_we    = ctl.if_id_we;
   assign bus.if_id_flush = ctl.if_id_flush;
   assign bus.id_ex_flush = ctl.id_ex_flush;
   assign bus.fetch_err   = err_q;

`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_bubbles_q, perf_bubbles_d;

   always_comb begin
      perf_fetched_d = perf_fetched_q;
      perf_bubbles_d = perf_bubbles_q;
      if (ctl.if_id_we && !ctl.if_id_flush)
         perf_fetched_d = perf_fetched_q + 32'd1;
      if (ctl.if_id_flush || bus.stall_id)
         perf_bubbles_d = perf_bubbles_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched_q <= 32'h0;
         perf_bubbles_q <= 32'h0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_bubbles_q <= perf_bubbles_d;
      end
   end

   assign bus.perf_fetched = perf_fetched_q;
   assign bus.perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: each driven cycle queues its expected outputs,
// which are popped and compared at the following falling edge.
module tb_fetch_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;

   fetch_ctrl_if bus ();

   fetch_ctrl #(
      .RESET_HOLD_CYCLES (2),
      .MAX_WAIT          (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        pc_we;
      logic        pc_sel;
      logic [31:0] rpc;
      logic        if_id_we;
      logic        if_id_flush;
      logic        id_ex_flush;
      logic        imem_req;
      logic        fetch_err;
   } exp_t;

   exp_t  sb_q[$];
   string tag_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t e_rst();
      exp_t e = '0;
      e.if_id_flush = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_norm();
      exp_t e = '0;
      e.pc_we = 1'b1; e.if_id_we = 1'b1; e.imem_req = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_stall();
      exp_t e = '0;
      e.imem_req = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_wait(input logic [31:0] rpc, input logic idex);
      exp_t e = '0;
      e.imem_req = 1'b1; e.if_id_flush = 1'b1; e.rpc = rpc; e.id_ex_flush = idex;
      return e;
   endfunction

   function automatic exp_t e_bypass(input logic [31:0] t);
      exp_t e = '0;
      e.imem_req = 1'b1; e.pc_we = 1'b1; e.pc_sel = 1'b1; e.rpc = t;
      e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_resume(input logic [31:0] t);
      exp_t e = '0;
      e.imem_req = 1'b1; e.pc_we = 1'b1; e.pc_sel = 1'b1; e.rpc = t; e.if_id_flush = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_err();
      exp_t e = '0;
      e.if_id_flush = 1'b1; e.fetch_err = 1'b1;
      return e;
   endfunction

   task automatic cyc(input string tag, input logic r, input logic b, input logic s,
                      input logic br, input logic [31:0] t, input exp_t e);
      @(posedge clk);
      #1;
      rst                  = r;
      bus.imem_busy        = b;
      bus.stall_id         = s;
      bus.branch_taken_ex  = br;
      bus.branch_target_ex = t;
      sb_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   always @(negedge clk) begin : monitor
      exp_t  e;
      string tg;
      if (sb_q.size() > 0) begin
         e  = sb_q.pop_front();
         tg = tag_q.pop_front();
         check_val({tg, ".pc_we"},       32'(bus.pc_we),       32'(e.pc_we));
         check_val({tg, ".pc_sel"},      32'(bus.pc_sel),      32'(e.pc_sel));
         check_val({tg, ".redirect_pc"}, bus.redirect_pc,      e.rpc);
         check_val({tg, ".if_id_we"},    32'(bus.if_id_we),    32'(e.if_id_we));
         check_val({tg, ".if_id_flush"}, 32'(bus.if_id_flush), 32'(e.if_id_flush));
         check_val({tg, ".id_ex_flush"}, 32'(bus.id_ex_flush), 32'(e.id_ex_flush));
         check_val({tg, ".imem_req"},    32'(bus.imem_req),    32'(e.imem_req));
         check_val({tg, ".fetch_err"},   32'(bus.fetch_err),   32'(e.fetch_err));
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.imem_busy        = 1'b0;
      bus.stall_id         = 1'b0;
      bus.branch_taken_ex  = 1'b0;
      bus.branch_target_ex = 32'h0;

      // reset held, then released: two hold cycles before the first fetch
      cyc("rst0", 0, 0, 0, 0, 32'h0, e_rst());
      cyc("rst1", 0, 0, 0, 0, 32'h0, e_rst());
      cyc("rel0", 1, 0, 0, 0, 32'h0, e_rst());
      cyc("rel1", 1, 0, 0, 0, 32'h0, e_rst());
      cyc("first", 1, 0, 0, 0, 32'h0, e_norm());

      for (int i = 0; i < 10; i++)
         cyc("line", 1, 0, 0, 0, 32'h0, e_norm());

      cyc("br40",    1, 0, 0, 1, 32'h0000_0040, e_bypass(32'h40));
      cyc("post_br", 1, 0, 0, 0, 32'h0, e_norm());

      // redirect captured while busy; younger 0xC0 ignored
      cyc("bb0",      1, 1, 0, 1, 32'h80, e_wait(32'h0, 1'b1));
      cyc("bb1",      1, 1, 0, 1, 32'hC0, e_wait(32'h80, 1'b0));
      cyc("bb2",      1, 1, 0, 0, 32'h0,  e_wait(32'h80, 1'b0));
      cyc("bb_done",  1, 0, 0, 0, 32'h0,  e_resume(32'h80));
      cyc("bb_after", 1, 0, 0, 0, 32'h0,  e_norm());

      cyc("stall",    1, 0, 1, 0, 32'h0,   e_stall());
      cyc("stall_br", 1, 0, 1, 1, 32'h100, e_bypass(32'h100));
      cyc("post_stl", 1, 0, 0, 0, 32'h0,   e_norm());

      // wait without a pending redirect, completing under a stall
      cyc("w0",      1, 1, 0, 0, 32'h0, e_wait(32'h0, 1'b0));
      cyc("w1",      1, 1, 0, 0, 32'h0, e_wait(32'h0, 1'b0));
      cyc("w_stall", 1, 0, 1, 0, 32'h0, e_stall());
      cyc("w_after", 1, 0, 0, 0, 32'h0, e_norm());

      // redirect captured inside S_WAIT
      cyc("wc0",     1, 1, 0, 0, 32'h0,   e_wait(32'h0, 1'b0));
      cyc("wc1",     1, 1, 0, 1, 32'h300, e_wait(32'h0, 1'b1));
      cyc("wc2",     1, 1, 0, 0, 32'h0,   e_wait(32'h300, 1'b0));
      cyc("wc_done", 1, 0, 0, 0, 32'h0,   e_resume(32'h300));
      cyc("wc_after",1, 0, 0, 0, 32'h0,   e_norm());

      // redirect arriving as imem completes is bypassed
      cyc("wb0",     1, 1, 0, 0, 32'h0,   e_wait(32'h0, 1'b0));
      cyc("wb1",     1, 0, 0, 1, 32'h340, e_bypass(32'h340));
      cyc("wb_after",1, 0, 0, 0, 32'h0,   e_norm());

      // reset mid-wait drops the pending redirect
      cyc("rw0",     1, 1, 0, 1, 32'h200, e_wait(32'h0, 1'b1));
      cyc("rw1",     1, 1, 0, 0, 32'h0,   e_wait(32'h200, 1'b0));
      cyc("rw_rst",  0, 1, 0, 0, 32'h0,   e_rst());
      cyc("rw_rel0", 1, 0, 0, 0, 32'h0,   e_rst());
      cyc("rw_rel1", 1, 0, 0, 0, 32'h0,   e_rst());
      cyc("rw_first",1, 0, 0, 0, 32'h0,   e_norm());
      cyc("rw_busy", 1, 1, 0, 0, 32'h0,   e_wait(32'h0, 1'b0));
      cyc("rw_clean",1, 0, 0, 0, 32'h0,   e_norm());

      // timeout after four busy S_WAIT cycles; flag sticks until reset
      cyc("to_f", 1, 1, 0, 0, 32'h0, e_wait(32'h0, 1'b0));
      for (int i = 0; i < 4; i++)
         cyc("to_w", 1, 1, 0, 0, 32'h0, e_wait(32'h0, 1'b0));
      cyc("err0",    1, 1, 0, 0, 32'h0,  e_err());
      cyc("err1",    1, 0, 0, 1, 32'h40, e_err());
      cyc("err2",    1, 0, 1, 0, 32'h0,  e_err());
      cyc("err_rst", 0, 0, 0, 0, 32'h0,  e_rst());
      cyc("err_rel", 1, 0, 0, 0, 32'h0,  e_rst());

      @(negedge clk);
      #1;
      check_val("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
